// File: rtl/axis_img_border_gen.sv
// axis_img_border_gen: surrounds each IMG_WIDTH x IMG_HEIGHT AXI4-Stream frame with a
// BORDER-pixel frame on every side. Original pixels carry BYPASS_BIT_MASK; border pixels never do.
// Optional feature macro: AXIS_IMG_BORDER_GEN_REPLICATE_EN (left/right borders replicate the
// nearest edge pixel of the row instead of BORDER_VALUE).
module axis_img_border_gen #(
  parameter int unsigned IMG_WIDTH       = 640,
  parameter int unsigned IMG_HEIGHT      = 480,
  parameter int unsigned BORDER          = 1,
  parameter logic [15:0] BYPASS_BIT_MASK = 16'h4000,
  parameter logic [15:0] BORDER_VALUE    = 16'h0000
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
);

  localparam int unsigned OW = IMG_WIDTH + 2 * BORDER;
  localparam int unsigned OH = IMG_HEIGHT + 2 * BORDER;
  localparam int unsigned CW = $clog2(OW);
  localparam int unsigned RW = $clog2(OH);

  localparam logic [CW-1:0] ColLast      = CW'(OW - 1);
  localparam logic [CW-1:0] ColLeftLast  = CW'(BORDER - 1);
  localparam logic [CW-1:0] ColInnerLast = CW'(BORDER + IMG_WIDTH - 1);
  localparam logic [RW-1:0] RowTopLast   = RW'(BORDER - 1);
  localparam logic [RW-1:0] RowInnerLast = RW'(BORDER + IMG_HEIGHT - 1);
  localparam logic [RW-1:0] RowLast      = RW'(OH - 1);
  localparam logic [15:0]   BorderPix    = BORDER_VALUE & ~BYPASS_BIT_MASK;

  typedef enum logic [2:0] {
    StWaitSof, StTop, StLeft, StInner, StRight, StBottom
  } state_e;

  state_e        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          load;
  logic          avail;
  logic          fire;
  logic          col_end;
  logic [15:0]   pix;

  // Row boundaries come from the parameters, so the input tlast carries no information.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

`ifdef AXIS_IMG_BORDER_GEN_REPLICATE_EN
  logic [15:0] last_q;

  // Remember the last inner pixel of the row for the right-hand border.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      last_q <= 16'h0000;
    end else if (fire && state_q == StInner && col_q == ColInnerLast) begin
      last_q <= s_axis_tdata;
    end
  end
`endif

  assign load    = ~m_axis_tvalid | m_axis_tready;
  assign fire    = load & avail;
  assign col_end = (col_q == ColLast);

  // Per-state beat availability, input ready and output pixel selection.
  always_comb begin
    avail         = 1'b0;
    s_axis_tready = 1'b0;
    pix           = BorderPix;
    unique case (state_q)
      StWaitSof: s_axis_tready = ~(s_axis_tvalid & s_axis_tuser);
      StTop, StBottom: avail = 1'b1;
      StLeft: begin
`ifdef AXIS_IMG_BORDER_GEN_REPLICATE_EN
        // Peek the first pixel of the row; valid data is held stable until accepted.
        avail = s_axis_tvalid;
        pix   = s_axis_tdata & ~BYPASS_BIT_MASK;
`else
        avail = 1'b1;
`endif
      end
      StInner: begin
        avail         = s_axis_tvalid;
        s_axis_tready = load;
        pix           = s_axis_tdata | BYPASS_BIT_MASK;
      end
      StRight: begin
        avail = 1'b1;
`ifdef AXIS_IMG_BORDER_GEN_REPLICATE_EN
        pix   = last_q & ~BYPASS_BIT_MASK;
`endif
      end
      default: ;
    endcase
  end

  // Frame sequencer, raster counters and registered output beat.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q       <= StWaitSof;
      col_q         <= '0;
      row_q         <= '0;
      m_axis_tdata  <= 16'h0000;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (load) begin
        m_axis_tvalid <= avail;
      end
      if (fire) begin
        m_axis_tdata <= pix;
        m_axis_tlast <= col_end;
        m_axis_tuser <= (col_q == '0) && (row_q == '0);
        col_q        <= col_end ? '0 : col_q + 1'b1;
        if (col_end) begin
          row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
        end
      end
      unique case (state_q)
        StWaitSof: if (s_axis_tvalid && s_axis_tuser) state_q <= StTop;
        StTop:     if (fire && col_end && row_q == RowTopLast) state_q <= StLeft;
        StLeft:    if (fire && col_q == ColLeftLast) state_q <= StInner;
        StInner:   if (fire && col_q == ColInnerLast) state_q <= StRight;
        StRight: begin
          if (fire && col_end) state_q <= (row_q == RowInnerLast) ? StBottom : StLeft;
        end
        StBottom:  if (fire && col_end && row_q == RowLast) state_q <= StWaitSof;
        default:   state_q <= StWaitSof;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_img_border_gen.sv
// Directed bench for axis_img_border_gen with a 4x2 image and a 1-pixel border.
module tb_axis_img_border_gen;

  localparam logic [15:0] Mask = 16'h4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_tdata = 16'h0000;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        s_tready, s_tready2;
  logic [15:0] m_tdata, m_tdata2;
  logic        m_tvalid, m_tvalid2, m_tlast, m_tlast2, m_tuser, m_tuser2;
  logic        m_tready = 1'b1;

  int n_tests = 0;
  int n_fail = 0;
  bit abort = 1'b0;

  logic [15:0] in_data [0:7];
  logic [15:0] got_d   [0:23];
  logic [15:0] got_d2  [0:23];
  logic        got_l   [0:23];
  logic        got_u   [0:23];
  int          span;

  always #5 clk = ~clk;

  axis_img_border_gen #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .BORDER(1),
    .BYPASS_BIT_MASK(16'h4000), .BORDER_VALUE(16'h0000)
  ) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
  );

  axis_img_border_gen #(
    .IMG_WIDTH(4), .IMG_HEIGHT(2), .BORDER(1),
    .BYPASS_BIT_MASK(16'h4000), .BORDER_VALUE(16'hFFFF)
  ) dut_fill (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast2), .m_axis_tuser(m_tuser2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected output pixel idx (raster order over the 6x4 output) for a given fill value.
  function automatic logic [15:0] exp_pix(input int idx, input logic [15:0] bval);
    int r = idx / 6;
    int c = idx % 6;
    logic [15:0] bp = bval & ~Mask;
    if (r == 0 || r == 3) return bp;
`ifdef AXIS_IMG_BORDER_GEN_REPLICATE_EN
    if (c == 0) return in_data[(r - 1) * 4] & ~Mask;
    if (c == 5) return in_data[(r - 1) * 4 + 3] & ~Mask;
`else
    if (c == 0 || c == 5) return bp;
`endif
    return in_data[(r - 1) * 4 + c - 1] | Mask;
  endfunction

  task automatic drive_frame(input int n_junk, input bit rnd);
    bit hs;
    int guard;
    for (int i = 0; i < n_junk + 8 && !abort; i++) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = (i < n_junk) ? 16'hAAAA : in_data[i - n_junk];
      s_tuser  = (i == n_junk);
      s_tlast  = (i >= n_junk) && ((i - n_junk) % 4 == 3);
      hs = 1'b0;
      guard = 0;
      while (!hs && !abort) begin
        #1;
        hs = s_tready;
        @(posedge clk);
        if (!hs) begin
          @(negedge clk);
          guard++;
          if (guard > 300) begin
            check("input_accept_timeout", 32'(guard), 32'd0);
            abort = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic collect(input int n_max, input bit rnd);
    int n_got = 0;
    int cyc = 0;
    int first_cyc = 0;
    bit held = 1'b0;
    logic [15:0] held_d = 16'h0000;
    while (n_got < n_max && cyc < 1000) begin
      @(negedge clk);
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cyc++;
      if (held) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_data", 32'(m_tdata), 32'(held_d));
      end
      if (m_tvalid && m_tready) begin
        if (n_got == 0) first_cyc = cyc;
        span = cyc - first_cyc;
        got_d[n_got]  = m_tdata;
        got_d2[n_got] = m_tdata2;
        got_l[n_got]  = m_tlast;
        got_u[n_got]  = m_tuser;
        n_got++;
        held = 1'b0;
      end else begin
        held   = m_tvalid;
        held_d = m_tdata;
      end
    end
    m_tready = 1'b1;
    check("beat_count", 32'(n_got), 32'(n_max));
  endtask

  task automatic verify_frame(input bit fill_too);
    for (int i = 0; i < 24; i++) begin
      check($sformatf("data[%0d]", i), 32'(got_d[i]), 32'(exp_pix(i, 16'h0000)));
      check($sformatf("last[%0d]", i), 32'(got_l[i]), 32'(i % 6 == 5));
      check($sformatf("user[%0d]", i), 32'(got_u[i]), 32'(i == 0));
      if (fill_too) check($sformatf("fill[%0d]", i), 32'(got_d2[i]), 32'(exp_pix(i, 16'hFFFF)));
    end
    repeat (3) @(negedge clk);
    #1;
    check("idle_after_frame", 32'(m_tvalid), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) in_data[i] = 16'(i + 1);

    // Power-on reset state.
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame at full rate: 24 beats in 24 consecutive cycles.
    fork
      drive_frame(0, 1'b0);
      collect(24, 1'b0);
    join
    check("full_rate_span", 32'(span), 32'd23);
    verify_frame(1'b0);

    // Three junk beats before SOF are discarded.
    fork
      drive_frame(3, 1'b0);
      collect(24, 1'b0);
    join
    verify_frame(1'b0);

    // Random source gaps and random sink back-pressure.
    fork
      drive_frame(0, 1'b1);
      collect(24, 1'b1);
    join
    verify_frame(1'b0);

    // Reset at output beat 10 aborts the frame.
    fork
      drive_frame(0, 1'b0);
      begin
        collect(10, 1'b0);
        abort = 1'b1;
      end
    join
    abort = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs();
    fork
      drive_frame(0, 1'b0);
      collect(24, 1'b0);
    join
    verify_frame(1'b0);

    // Saturated input data and an all-ones fill value.
    for (int i = 0; i < 8; i++) in_data[i] = 16'h7FFF;
    fork
      drive_frame(0, 1'b0);
      collect(24, 1'b0);
    join
    verify_frame(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_img_border_gen.md
# axis_img_border_gen

Streaming AXI4-Stream frame border generator. Surrounds each IMG_WIDTH x IMG_HEIGHT input frame with BORDER pixels on every side. Original pixels carry the bypass bit; border pixels never do. Sits upstream of the border-dependent DIP kernels (BPR filters), so the downstream border remover can later strip the border by the bypass bit alone.

## Interface
- IMG_WIDTH, 640: input pixels per row (>= 1)
- IMG_HEIGHT, 480: input rows per frame (>= 1)
- BORDER, 1: border thickness in pixels per side (>= 1)
- BYPASS_BIT_MASK, 16'h4000: bit marking original pixels
- BORDER_VALUE, 16'h0000: fill value for border pixels; BYPASS_BIT_MASK bits are forced to 0
- axis_aclk  in  1  clock, all logic on rising edge
- axis_aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  16  input pixel
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready; combinational
- s_axis_tlast  in  1  input end of row; ignored, geometry comes from parameters
- s_axis_tuser  in  1  input start of frame
- m_axis_tdata  out  16  output pixel; registered
- m_axis_tvalid  out  1  output valid; registered
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of row; registered
- m_axis_tuser  out  1  output start of frame; registered

## Operation
- Output geometry: OW = IMG_WIDTH+2*BORDER, OH = IMG_HEIGHT+2*BORDER.
- Counters col (0..OW-1) and row (0..OH-1) are $clog2 wide. They advance on each output beat loaded into the output register.
- Output register loads when `load = ~m_axis_tvalid | m_axis_tready` and a beat is available.
- States:
  - ST_WAIT_SOF: s_axis_tready=1 for beats without tuser, which are consumed and discarded. When s_axis_tvalid & s_axis_tuser, go to ST_TOP without consuming the beat.
  - ST_TOP: emit BORDER rows of border pixels, then go to ST_LEFT.
  - ST_LEFT: emit BORDER border pixels, then go to ST_INNER.
  - ST_INNER: s_axis_tready = load. Each accepted beat outputs `(s_axis_tdata | BYPASS_BIT_MASK)`. After IMG_WIDTH beats, go to ST_RIGHT.
  - ST_RIGHT: emit BORDER border pixels. Then go to ST_LEFT, or to ST_BOTTOM after the last inner row.
  - ST_BOTTOM: emit BORDER border rows, then go to ST_WAIT_SOF.
- Border pixel data is `BORDER_VALUE & ~BYPASS_BIT_MASK`. Border states emit one beat per load cycle and do not depend on the input.
- m_axis_tuser=1 only at row 0, col 0. m_axis_tlast=1 at col OW-1 of every row.
- s_axis_tready=0 in every state except ST_WAIT_SOF and ST_INNER.
- An input tuser arriving mid-frame in ST_INNER is treated as a normal pixel; the frame completes by counters. Resync happens only at the next ST_WAIT_SOF.
- Reset (any time, including mid-frame) aborts the frame: counters clear, state goes to ST_WAIT_SOF, and no partial frame resumes.

## Timing
- Reset values: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, state=ST_WAIT_SOF, col=row=0. s_axis_tready=1 after reset.
- Latency is 1 cycle from input accept to m_axis_tvalid.
- Throughput is 1 beat/cycle with m_axis_tready held high. A frame takes OW*OH output cycles.
- m_axis_tdata/tlast/tuser are held stable while m_axis_tvalid & ~m_axis_tready.
- Input and output handshakes in the same cycle are fully pipelined, with no bubble.

## Configuration
- Macro: AXIS_IMG_BORDER_GEN_REPLICATE_EN.
- Defined: left and right border pixels replicate the nearest edge pixel of the current row, with the bypass bit cleared.
  - ST_LEFT emits only while s_axis_tvalid. It peeks s_axis_tdata without consuming it; valid data is stable under AXIS rules.
  - ST_RIGHT uses a register holding the last inner pixel of the row.
  - Top and bottom borders stay BORDER_VALUE.
- Undefined: all border pixels are BORDER_VALUE, and the replicate register is absent.

## Test plan
- IMG 4x2, BORDER=1, input frame 0x0001..0x0008, m_axis_tready=1:
  - 24 beats are output.
  - Row 1 is 0000,4001,4002,4003,4004,0000, with tlast on beats 6/12/18/24 and tuser on beat 1 only.
- Same frame preceded by 3 non-tuser beats: those beats are discarded, and the output is identical to the first case.
- Random m_axis_tready (50%) and random s_axis_tvalid: the output sequence matches the first case exactly, and data is stable during stalls.
- Reset asserted at output beat 10, then a new frame: after reset all outputs are 0. The next frame starts with tuser and a full 24-beat frame.
- Input data 0x7FFF in ST_INNER outputs 0x7FFF. BORDER_VALUE=16'hFFFF outputs 0xBFFF on border pixels.
- With AXIS_IMG_BORDER_GEN_REPLICATE_EN, first case: row 1 is 0001,4001,4002,4003,4004,0004, and rows 0 and 3 are all 0000.
